// File: rtl/test_sequencer_pkg.sv
// Shared definitions for the test sequencer: state encoding, default
// phase lengths and a small state-classification helper.
package test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FREEZE = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  localparam int DEFAULT_CLEAR_CYCLES = 2;
  localparam int DEFAULT_DRAIN_CYCLES = 4;

  function automatic logic is_busy(input seq_state_t s);
    return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_FREEZE);
  endfunction

endpackage

// File: rtl/test_sequencer_seq_timer.sv
// Loadable down-counter with a zero flag; times both the CLEAR and DRAIN
// phases of the sequencer.
module seq_timer
  import test_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/test_sequencer.sv
// Campaign sequencer: resets, drives, drains and freezes a testbench, then
// reports the captured scoreboard event count as pass/fail.
module test_sequencer
  import test_sequencer_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_num_vectors,
  input  logic [WIDTH-1:0] i_max_events,
  input  logic [WIDTH-1:0] i_event_ctr,
  output logic             o_tb_reset,
  output logic             o_tb_enable,
  output logic             o_tb_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_early_stop,
  output logic [WIDTH-1:0] o_vec_ctr,
  output logic [WIDTH-1:0] o_result_events
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [WIDTH-1:0] r_num_vectors;
  logic [WIDTH-1:0] r_max_events;

  logic             w_launch;
  logic             w_vec_limit;
  logic             w_event_hit;
  logic             w_timer_zero;
  logic             w_timer_load;
  logic             w_timer_dec;
  logic [WIDTH-1:0] w_timer_value;

  logic             w_tb_reset;
  logic             w_tb_enable;
  logic             w_tb_freeze;
  logic             w_busy;
  logic             w_done;

  assign w_launch    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start && !i_abort;
  assign w_vec_limit = (o_vec_ctr == (r_num_vectors - WIDTH'(1)));
  assign w_event_hit = (r_max_events != '0) && (i_event_ctr >= r_max_events);

  // Timer is loaded with length-1 on phase entry so the phase lasts exactly length cycles.
  assign w_timer_load  = ((w_next_state == ST_CLEAR) && (r_state != ST_CLEAR)) ||
                         ((w_next_state == ST_DRAIN) && (r_state != ST_DRAIN));
  assign w_timer_value = (w_next_state == ST_CLEAR) ? WIDTH'(CLEAR_CYCLES - 1)
                                                    : WIDTH'(DRAIN_CYCLES - 1);
  assign w_timer_dec   = (r_state == ST_CLEAR) || (r_state == ST_DRAIN);

  seq_timer #(.WIDTH(WIDTH)) u_timer (
    .clk_dut (clk_dut),
    .reset   (reset),
    .i_load  (w_timer_load),
    .i_value (w_timer_value),
    .i_dec   (w_timer_dec),
    .o_zero  (w_timer_zero)
  );

  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      o_tb_reset  <= 1'b1;
      o_tb_enable <= 1'b0;
      o_tb_freeze <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      o_tb_reset  <= w_tb_reset;
      o_tb_enable <= w_tb_enable;
      o_tb_freeze <= w_tb_freeze;
      o_busy      <= w_busy;
      o_done      <= w_done;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (i_start) w_next_state = ST_CLEAR;
        ST_CLEAR:  if (w_timer_zero) w_next_state = (r_num_vectors == '0) ? ST_FREEZE : ST_RUN;
        ST_RUN:    if (w_vec_limit || w_event_hit) w_next_state = ST_DRAIN;
        ST_DRAIN:  if (w_timer_zero) w_next_state = ST_FREEZE;
        ST_FREEZE: w_next_state = ST_DONE;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  // Control outputs are decoded from the next state and registered alongside it.
  always_comb begin
    w_tb_reset  = (w_next_state == ST_CLEAR);
    w_tb_enable = (w_next_state == ST_RUN);
    w_tb_freeze = (w_next_state == ST_FREEZE) || (w_next_state == ST_DONE);
    w_busy      = is_busy(w_next_state);
    w_done      = (w_next_state == ST_DONE);
  end

  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      r_num_vectors   <= '0;
      r_max_events    <= '0;
      o_vec_ctr       <= '0;
      o_early_stop    <= 1'b0;
      o_pass          <= 1'b0;
      o_result_events <= '0;
    end else if (w_launch) begin
      r_num_vectors   <= i_num_vectors;
      r_max_events    <= i_max_events;
      o_vec_ctr       <= '0;
      o_early_stop    <= 1'b0;
      o_pass          <= 1'b0;
      o_result_events <= '0;
    end else begin
      if (r_state == ST_RUN) begin
        o_vec_ctr <= o_vec_ctr + WIDTH'(1);
      end
      if ((r_state == ST_RUN) && w_event_hit && !i_abort) begin
        o_early_stop <= 1'b1;
      end
      if ((r_state == ST_FREEZE) && !i_abort) begin
        o_result_events <= i_event_ctr;
        o_pass          <= (i_event_ctr == '0);
      end
    end
  end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, datapath and counter width.
REQ-002 Parameter DRAIN_CYCLES, default 4, cycles to let DUT and monitor pipelines empty after stimulus stops.
REQ-003 Parameter CLEAR_CYCLES, default 2, cycles the testbench reset is held at campaign start.
REQ-004 clk_dut  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  level; sampled in IDLE or DONE, launches a campaign.
REQ-007 i_abort  in  1  level; terminates any campaign.
REQ-008 i_num_vectors  in  WIDTH  vectors to apply; latched on start.
REQ-009 i_max_events  in  WIDTH  early-stop threshold, 0 = disabled; latched on start.
REQ-010 i_event_ctr  in  WIDTH  live scoreboard event count.
REQ-011 o_tb_reset  out  1  active-high synchronous reset to testbench.
REQ-012 o_tb_enable  out  1  randomiser enable.
REQ-013 o_tb_freeze  out  1  scoreboard freeze.
REQ-014 o_busy / o_done / o_pass / o_early_stop  out  1 each  status.
REQ-015 o_vec_ctr  out  WIDTH  vectors issued this campaign.
REQ-016 o_result_events  out  WIDTH  event count captured at freeze.

Function
REQ-017 States IDLE, CLEAR, RUN, DRAIN, FREEZE, DONE; o_busy = 1 in CLEAR, RUN, DRAIN, FREEZE.
REQ-018 IDLE or DONE with i_start=1: next state CLEAR; latch parameters; clear o_vec_ctr, o_done, o_pass, o_early_stop, o_result_events.
REQ-019 CLEAR: o_tb_reset=1 for exactly CLEAR_CYCLES cycles, then RUN (or FREEZE when latched num_vectors = 0).
REQ-020 RUN: o_tb_enable=1; o_vec_ctr increments once per cycle; after exactly num_vectors enable cycles, next state DRAIN.
REQ-021 RUN early stop: max_events != 0 and i_event_ctr >= max_events -> next state DRAIN, o_early_stop set; the final enable cycle is the one in which the condition was detected.
REQ-022 Vector limit and early stop in the same cycle: DRAIN, o_early_stop set.
REQ-023 DRAIN: o_tb_enable=0 for exactly DRAIN_CYCLES cycles, then FREEZE.
REQ-024 FREEZE: o_tb_freeze=1 for one cycle; i_event_ctr registered into o_result_events; next state DONE.
REQ-025 DONE: o_tb_freeze stays 1; o_done=1; o_pass = (o_result_events == 0); hold until a new start or abort.
REQ-026 i_abort=1 in any state: next state IDLE; tb_enable and tb_freeze are 0 and o_done=0 from the following cycle; abort beats a simultaneous start.
REQ-027 i_start is ignored while o_busy=1; a start held high in DONE relaunches (level-sensitive).
REQ-028 o_vec_ctr never wraps: num_vectors <= 2^WIDTH-1 is reached before overflow.
REQ-029 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-030 reset low: state IDLE asynchronously; all status, counters and results 0; o_tb_reset=1 while in reset and for the first IDLE cycle after reset release, else 0 in IDLE.
REQ-031 Reset mid-campaign discards all latched parameters and results.

Structure
REQ-032 The state encoding and default CLEAR_CYCLES/DRAIN_CYCLES constants live in the shared testbench package.
REQ-033 One sub-module, seq_timer (loadable down-counter with zero flag), is shared by CLEAR and DRAIN timing.

Verification
REQ-034 num_vectors=10, max_events=0, events stay 0 -> tb_reset high 2 cycles, tb_enable high exactly 10 cycles, 4 drain cycles, freeze, o_done=1, o_pass=1, o_vec_ctr=10.
REQ-035 num_vectors=100, max_events=3, event_ctr reaches 3 at vector 20 -> o_early_stop=1, o_vec_ctr=20, o_result_events>=3, o_pass=0.
REQ-036 num_vectors=0 -> CLEAR 2 cycles, no enable cycles, FREEZE, DONE with o_pass=1, o_vec_ctr=0.
REQ-037 Abort at RUN cycle 5 of 50 -> IDLE next cycle, tb_enable=0, o_done=0; start pulse during RUN ignored.
REQ-038 reset asserted in DRAIN -> all outputs 0 immediately except o_tb_reset=1; after release a new start runs a clean campaign.
REQ-039 start and abort high together in IDLE -> stays IDLE.
